// File: rtl/toggle_rx_pkg.sv
// Shared limits, channel-index width helper and pending-counter type for the
// multi-channel toggle receiver.
package toggle_rx_pkg;

  localparam int N_CH_MIN        = 1;
  localparam int N_CH_MAX        = 32;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int CNT_W_MIN       = 1;
  localparam int CNT_W_MAX       = 8;

  // Wide enough for the largest counter; narrower builds saturate below the top bits.
  typedef logic [CNT_W_MAX-1:0] pend_cnt_t;

  function automatic int clamp_param(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int ch_idx_w(input int n);
    int m;
    m = clamp_param(n, N_CH_MIN, N_CH_MAX);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/toggle_sync_bit.sv
// Single-bit synchronizer chain for one asynchronous toggle line.
module toggle_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/multi_toggle_receiver.sv
// N-channel toggle receiver: synchronize, edge-detect, count and serialize events
// round-robin. Overflow flags are built only when TOGGLE_RX_OVF_EN is defined.
module multi_toggle_receiver
  import toggle_rx_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic                                        clk_i,
  input  logic                                        arst_i,
  input  logic [N_CH-1:0]                             tgl_i,
  output logic [N_CH-1:0]                             pulse_o,
  output logic                                        evt_valid_o,
  input  logic                                        evt_ready_i,
  output logic [toggle_rx_pkg::ch_idx_w(N_CH)-1:0]    evt_ch_o,
  output logic [N_CH-1:0]                             ovf_o,
  input  logic [N_CH-1:0]                             ovf_clr_i
);

  localparam int              SYNC_C    = clamp_param(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  localparam int              CNT_W_C   = clamp_param(CNT_W, CNT_W_MIN, CNT_W_MAX);
  localparam int              CH_W      = ch_idx_w(N_CH);
  localparam pend_cnt_t       PEND_MAX  = pend_cnt_t'((1 << CNT_W_C) - 1);
  localparam logic [2:0]      WARM_INIT = 3'(SYNC_C + 1);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(N_CH - 1);

  logic [N_CH-1:0] sync_last;
  logic [N_CH-1:0] hist_p1;
  logic [N_CH-1:0] pulse;
  logic [N_CH-1:0] req;
  logic [N_CH-1:0] dec;
  logic [N_CH-1:0] lost;
  pend_cnt_t       pend [N_CH];
  logic [2:0]      warm_cnt;
  logic            warm_done;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] sel;
  logic [CH_W-1:0] cand;
  logic            found;
  logic            load;

  function automatic pend_cnt_t pend_next(input pend_cnt_t cur, input logic inc, input logic dec_en);
    pend_cnt_t nxt;
    nxt = cur;
    if (inc && !dec_en && (cur != PEND_MAX)) begin
      nxt = cur + 1'b1;
    end else if (dec_en && !inc) begin
      nxt = cur - 1'b1;
    end
    return nxt;
  endfunction

  function automatic int rr_idx(input logic [CH_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return (s >= N_CH) ? (s - N_CH) : s;
  endfunction

  // Synchronizer stages, then history for edge detection
  for (genvar c = 0; c < N_CH; c++) begin : g_sync
    toggle_sync_bit #(.STAGES(SYNC_C)) u_sync (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .d_i    (tgl_i[c]),
      .q_o    (sync_last[c])
    );
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      hist_p1  <= '0;
      warm_cnt <= WARM_INIT;
    end else begin
      hist_p1 <= sync_last;
      if (warm_cnt != '0) begin
        warm_cnt <= warm_cnt - 1'b1;
      end
    end
  end

  // History keeps tracking during warm-up so a level held across reset is absorbed.
  assign warm_done = (warm_cnt == '0);
  assign pulse     = (sync_last ^ hist_p1) & {N_CH{warm_done}};
  assign pulse_o   = pulse;

  // Pending counters and round-robin selection
  assign load = !evt_valid_o || evt_ready_i;

  for (genvar c = 0; c < N_CH; c++) begin : g_pend
    assign req[c]  = pulse[c] || (pend[c] != '0);
    assign dec[c]  = load && found && (sel == CH_W'(c));
    assign lost[c] = pulse[c] && !dec[c] && (pend[c] == PEND_MAX);

    always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
        pend[c] <= '0;
      end else begin
        pend[c] <= pend_next(pend[c], pulse[c], dec[c]);
      end
    end
  end

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = CH_W'(rr_idx(rr_ptr, i));
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Output register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      evt_valid_o <= 1'b0;
      evt_ch_o    <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      evt_valid_o <= found;
      if (found) begin
        evt_ch_o <= sel;
        rr_ptr   <= (sel == LAST_CH) ? '0 : sel + 1'b1;
      end
    end
  end

`ifdef TOGGLE_RX_OVF_EN
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      ovf_o <= '0;
    end else begin
      ovf_o <= lost | (ovf_o & ~ovf_clr_i);
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = ^{ovf_clr_i, lost};
  assign ovf_o      = '0;
`endif

endmodule

// File: tb/tb_multi_toggle_receiver.sv
// Directed bench for multi_toggle_receiver (N_CH=4, SYNC_STAGES=2, CNT_W=2).
module tb_multi_toggle_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] tgl;
  logic [3:0] pulse;
  logic       valid;
  logic       ready;
  logic [1:0] ch;
  logic [3:0] ovf;
  logic [3:0] clr;

  int total = 0;
  int bad   = 0;
  logic [1:0] ev_q[$];

`ifdef TOGGLE_RX_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  multi_toggle_receiver #(.N_CH(4), .SYNC_STAGES(2), .CNT_W(2)) dut (
    .clk_i       (clk),
    .arst_i      (rst),
    .tgl_i       (tgl),
    .pulse_o     (pulse),
    .evt_valid_o (valid),
    .evt_ready_i (ready),
    .evt_ch_o    (ch),
    .ovf_o       (ovf),
    .ovf_clr_i   (clr)
  );

  // Handshakes are captured half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (!rst && valid && ready) ev_q.push_back(ch);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(6);
  endtask

  task automatic test_reset;
    rst = 1'b1; tgl = 4'b0001; ready = 1'b1; clr = 4'b0000;
    tick(3);
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (ch !== 2'd0) begin bad++; $display("FAIL reset_ch: got %0d want 0", ch); end
    total++; if (pulse !== 4'b0000) begin bad++; $display("FAIL reset_pulse: got %b want 0000", pulse); end
    total++; if (ovf !== 4'b0000) begin bad++; $display("FAIL reset_ovf: got %b want 0000", ovf); end
    tick(1);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (pulse !== 4'b0000 || valid !== 1'b0) begin
        bad++; $display("FAIL warmup_quiet[%0d]: pulse=%b valid=%b want 0000/0", k, pulse, valid);
      end
    end
    total++; if (ev_q.size() != 0) begin bad++; $display("FAIL warmup_events: got %0d want 0", ev_q.size()); end
  endtask

  task automatic test_single;
    ev_q.delete();
    tick(1);
    tgl[2] = ~tgl[2];
    @(negedge clk);
    @(negedge clk);
    total++; if (pulse !== 4'b0000) begin bad++; $display("FAIL single_early: got %b want 0000", pulse); end
    @(negedge clk);
    total++; if (pulse !== 4'b0100) begin bad++; $display("FAIL single_pulse: got %b want 0100", pulse); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_valid_early: got %b want 0", valid); end
    @(negedge clk);
    total++; if (pulse !== 4'b0000) begin bad++; $display("FAIL single_pulse_len: got %b want 0000", pulse); end
    total++; if (valid !== 1'b1 || ch !== 2'd2) begin bad++; $display("FAIL single_evt: valid=%b ch=%0d want 1/2", valid, ch); end
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL single_evt_len: got %b want 0", valid); end
    total++; if (ev_q.size() != 1) begin bad++; $display("FAIL single_count: got %0d want 1", ev_q.size()); end
    else begin
      total++; if (ev_q[0] !== 2'd2) begin bad++; $display("FAIL single_q_ch: got %0d want 2", ev_q[0]); end
    end
  endtask

  task automatic test_back_to_back;
    ev_q.delete();
    tick(1);
    tgl = tgl ^ 4'b0110;
    repeat (3) @(negedge clk);
    total++; if (pulse !== 4'b0110) begin bad++; $display("FAIL b2b_pulse: got %b want 0110", pulse); end
    @(negedge clk);
    total++; if (valid !== 1'b1 || ch !== 2'd1) begin bad++; $display("FAIL b2b_first: valid=%b ch=%0d want 1/1", valid, ch); end
    @(negedge clk);
    total++; if (valid !== 1'b1 || ch !== 2'd2) begin bad++; $display("FAIL b2b_second: valid=%b ch=%0d want 1/2", valid, ch); end
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", valid); end
    tick(1);
    tgl[0] = ~tgl[0];
    tick(1);
    tgl[0] = ~tgl[0];
    @(negedge clk);
    @(negedge clk);
    total++; if (pulse !== 4'b0001) begin bad++; $display("FAIL dbl_pulse1: got %b want 0001", pulse); end
    @(negedge clk);
    total++; if (pulse !== 4'b0001) begin bad++; $display("FAIL dbl_pulse2: got %b want 0001", pulse); end
    total++; if (valid !== 1'b1 || ch !== 2'd0) begin bad++; $display("FAIL dbl_evt1: valid=%b ch=%0d want 1/0", valid, ch); end
    @(negedge clk);
    total++; if (valid !== 1'b1 || ch !== 2'd0) begin bad++; $display("FAIL dbl_evt2: valid=%b ch=%0d want 1/0", valid, ch); end
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL dbl_idle: got %b want 0", valid); end
    total++; if (ev_q.size() != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", ev_q.size()); end
    else begin
      total++;
      if (ev_q[0] !== 2'd1 || ev_q[1] !== 2'd2 || ev_q[2] !== 2'd0 || ev_q[3] !== 2'd0) begin
        bad++; $display("FAIL b2b_order: got %0d %0d %0d %0d want 1 2 0 0", ev_q[0], ev_q[1], ev_q[2], ev_q[3]);
      end
    end
  endtask

  task automatic test_stall;
    ev_q.delete();
    do_reset();
    total++; if (ev_q.size() != 0) begin bad++; $display("FAIL held_level_events: got %0d want 0", ev_q.size()); end
    ready = 1'b0;
    tick(1);
    tgl = tgl ^ 4'b1111;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (valid !== 1'b1 || ch !== 2'd0) begin
        bad++; $display("FAIL stall_hold[%0d]: valid=%b ch=%0d want 1/0", k, valid, ch);
      end
    end
    tick(1);
    ready = 1'b1;
    tick(8);
    total++; if (ev_q.size() != 4) begin bad++; $display("FAIL stall_count: got %0d want 4", ev_q.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (ev_q[k] !== 2'(k)) begin bad++; $display("FAIL stall_order[%0d]: got %0d want %0d", k, ev_q[k], k); end
      end
    end
  endtask

  task automatic test_overflow;
    int n1;
    ev_q.delete();
    ready = 1'b0;
    tgl[0] = ~tgl[0];
    tick(5);
    for (int k = 0; k < 5; k++) begin
      tgl[1] = ~tgl[1];
      tick(3);
    end
    @(negedge clk);
    total++; if (ovf !== {2'b00, OVF_ON, 1'b0}) begin bad++; $display("FAIL ovf_set: got %b want %b", ovf, {2'b00, OVF_ON, 1'b0}); end
    tick(1);
    ready = 1'b1;
    tick(10);
    n1 = 0;
    foreach (ev_q[i]) if (ev_q[i] == 2'd1) n1++;
    total++; if (ev_q.size() != 4) begin bad++; $display("FAIL ovf_total: got %0d want 4", ev_q.size()); end
    total++; if (n1 != 3) begin bad++; $display("FAIL ovf_ch1_events: got %0d want 3", n1); end
  endtask

  task automatic test_ovf_clear;
    clr = 4'b0010;
    tick(1);
    clr = 4'b0000;
    @(negedge clk);
    total++; if (ovf !== 4'b0000) begin bad++; $display("FAIL ovf_clr_alone: got %b want 0000", ovf); end
    tick(1);
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tgl[1] = ~tgl[1];
      tick(3);
    end
    @(negedge clk);
    total++; if (ovf !== 4'b0000) begin bad++; $display("FAIL ovf_full_no_loss: got %b want 0000", ovf); end
    tick(1);
    tgl[1] = ~tgl[1];
    tick(2);
    clr = 4'b0010;
    tick(1);
    @(negedge clk);
    total++; if (ovf !== {2'b00, OVF_ON, 1'b0}) begin bad++; $display("FAIL ovf_set_wins: got %b want %b", ovf, {2'b00, OVF_ON, 1'b0}); end
    tick(1);
    clr = 4'b0000;
    @(negedge clk);
    total++; if (ovf !== 4'b0000) begin bad++; $display("FAIL ovf_clr_next: got %b want 0000", ovf); end
    tick(1);
    ready = 1'b1;
    tick(10);
  endtask

  task automatic test_reset_mid;
    ev_q.delete();
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tgl[3] = ~tgl[3];
      tick(4);
    end
    @(negedge clk);
    total++; if (valid !== 1'b1 || ch !== 2'd3) begin bad++; $display("FAIL mid_pre: valid=%b ch=%0d want 1/3", valid, ch); end
    tick(1);
    rst = 1'b1;
    #1;
    total++; if (valid !== 1'b0 || ch !== 2'd0) begin bad++; $display("FAIL mid_rst_evt: valid=%b ch=%0d want 0/0", valid, ch); end
    total++; if (pulse !== 4'b0000 || ovf !== 4'b0000) begin bad++; $display("FAIL mid_rst_flags: pulse=%b ovf=%b want 0000/0000", pulse, ovf); end
    tick(2);
    rst = 1'b0;
    ready = 1'b1;
    tick(12);
    total++; if (ev_q.size() != 0) begin bad++; $display("FAIL mid_no_events: got %0d want 0", ev_q.size()); end
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL mid_idle: got %b want 0", valid); end
  endtask

  initial begin
    rst = 1'b1; tgl = 4'b0000; ready = 1'b1; clr = 4'b0000;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_ovf_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_toggle_receiver.md
MULTI_TOGGLE_RECEIVER -- requirements
Module: multi_toggle_receiver

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent toggle channels (1..32).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth per channel (2..4).
REQ-003 SHALL have parameter CNT_W, default 4, width of per-channel pending-event counter (1..8).
REQ-004 SHALL have port clk_i, input, 1, single clock; all logic in this domain.
REQ-005 SHALL have port arst_i, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port tgl_i, input, N_CH, asynchronous toggle lines; each level change = one event.
REQ-007 SHALL have port pulse_o, output, N_CH, one-cycle event pulse per channel.
REQ-008 SHALL have port evt_valid_o, output, 1, serialized event available.
REQ-009 SHALL have port evt_ready_i, input, 1, downstream accepts event.
REQ-010 SHALL have port evt_ch_o, output, max(1,$clog2(N_CH)), channel index of offered event.
REQ-011 SHALL have port ovf_o, output, N_CH, sticky per-channel overflow flag.
REQ-012 SHALL have port ovf_clr_i, input, N_CH, per-channel overflow clear.

Function
REQ-013 Each tgl_i bit SHALL pass through SYNC_STAGES flops, then one history flop; pulse_o[c] = last stage XOR history.
REQ-014 A level change first sampled at edge E SHALL give pulse_o[c]=1 for exactly one cycle, after edge E+SYNC_STAGES-1.
REQ-015 Two toggles spaced >= 1 cycle after synchronization SHALL give two separate pulses; none merged.
REQ-016 pend[c] SHALL increment on pulse_o[c], decrement when channel c loads the output register, stay unchanged when both occur.
REQ-017 pend[c] SHALL saturate at 2^CNT_W-1; a pulse while saturated without same-cycle decrement is lost.
REQ-018 Output register SHALL load when empty or when evt_valid_o && evt_ready_i in the same cycle.
REQ-019 Load selection SHALL be round-robin over channels with pend!=0, starting at the channel after the last loaded; pointer reset 0.
REQ-020 evt_valid_o and evt_ch_o SHALL be registered, held stable while evt_valid_o && !evt_ready_i.
REQ-021 Sustained evt_ready_i=1 SHALL sustain one event per cycle; latency pulse to evt_valid_o = 1 cycle when idle.
REQ-022 ovf_o[c] SHALL set on a lost event (REQ-017) and clear on ovf_clr_i[c]; set wins on simultaneous set/clear.

Reset
REQ-023 arst_i SHALL asynchronously clear sync flops, history, pend, pointer, evt_valid_o, evt_ch_o, ovf_o, pulse_o to 0.
REQ-024 After deassertion, a warm-up counter SHALL suppress pulse_o for SYNC_STAGES+1 cycles while history tracks the last stage, so a line held high across reset yields no event.
REQ-025 Reset mid-operation SHALL discard all pending and in-flight events without emitting any.

Configuration
REQ-026 With TOGGLE_RX_OVF_EN defined, overflow detection per REQ-022 SHALL be present.
REQ-027 Without TOGGLE_RX_OVF_EN, ovf_o SHALL be constant 0, ovf_clr_i ignored; saturation (REQ-017) remains.

Structure
REQ-028 Package toggle_rx_pkg SHALL hold parameter limits, the channel-index width function, and the pending-counter typedef.
REQ-029 Sub-module toggle_sync_bit SHALL implement one synchronizer chain with ASYNC_REG on all stages; instantiated N_CH times.

Verification
REQ-030 N_CH=4, SYNC_STAGES=2: single toggle on tgl_i[2] -> pulse_o[2] one cycle after 2 edges; evt_valid_o next cycle, evt_ch_o=2.
REQ-031 tgl_i[0] high before and across arst_i release -> no pulse, no event during 3-cycle warm-up or after.
REQ-032 evt_ready_i=0, toggle all 4 channels once -> events 0,1,2,3 in order after ready=1; evt_ch_o stable while stalled.
REQ-033 CNT_W=2, ready=0, 5 toggles on ch1 -> pend=3, ovf_o[1]=1 (macro on) or 0 (macro off); exactly 3 events emitted.
REQ-034 ovf_clr_i[1] same cycle as new overflow -> ovf_o[1] stays 1; clear alone next cycle -> 0.
REQ-035 arst_i asserted with pend[3]=2 and evt_valid_o=1 -> all outputs 0 immediately; no events after release.
